// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned PC_INC           = 4;
  localparam int unsigned INSTR_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen.sv
// RV32 fetch program-counter generator: step, redirect, halt/resume.
// Optional PC_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC with a one-cycle trap_pulse.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            trap_pulse
);

  localparam logic [XLEN-1:0] AlignMask = ~XLEN'((1 << INSTR_ALIGN_BITS) - 1);

  pc_state_t       state;
  logic            handshake;
  logic            redirect_take;
  logic [XLEN-1:0] pc_next;
  logic            trap_next;

  // Next-pc mux: redirect beats increment; redirects are dropped while booting.
  always_comb begin
    handshake     = fetch_valid & fetch_ready;
    redirect_take = redirect_valid && (state != BOOT);
    pc_next       = pc;
    trap_next     = 1'b0;
    if (redirect_take) begin
`ifdef PC_MISALIGN_TRAP_EN
      if ((redirect_pc & ~AlignMask) != '0) begin
        pc_next   = TRAP_VEC;
        trap_next = 1'b1;
      end else begin
        pc_next = redirect_pc;
      end
`else
      pc_next = redirect_pc & AlignMask;
`endif
    end else if (handshake) begin
      pc_next = pc + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      trap_pulse  <= 1'b0;
    end else begin
      pc         <= pc_next;
      trap_pulse <= trap_next;
      unique case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          // Halt only once the outstanding address has been accepted.
          if (halt_req && handshake) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        HALT: begin
          if (resume && !halt_req) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic, checked against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] ResetVec = 32'h0;
  localparam logic [31:0] TrapVec  = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        halted;
  logic        trap_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_booting = 1'b1;
  bit          m_halted  = 1'b0;
  logic [31:0] m_pc      = ResetVec;
  bit          m_trap    = 1'b0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .halted         (halted),
    .trap_pulse     (trap_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the model, using the inputs presented to the DUT for that clock.
  task automatic model_step();
    bit issuing;
    bit accepted;
    if (rst) begin
      m_booting = 1'b1;
      m_halted  = 1'b0;
      m_pc      = ResetVec;
      m_trap    = 1'b0;
      return;
    end
    issuing  = !m_booting && !m_halted;
    accepted = issuing && fetch_ready;
    m_trap   = 1'b0;
    if (!m_booting && redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (redirect_pc % 4 != 0) begin
        m_pc   = TrapVec;
        m_trap = 1'b1;
      end else begin
        m_pc = redirect_pc;
      end
`else
      m_pc = redirect_pc - (redirect_pc % 4);
`endif
    end else if (accepted) begin
      m_pc = m_pc + 32'd4;
    end
    if (m_booting) m_booting = 1'b0;
    else if (m_halted) begin
      if (resume && !halt_req) m_halted = 1'b0;
    end else if (halt_req && accepted) m_halted = 1'b1;
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit hr,
                      input bit res, input bit rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    resume         = res;
    fetch_ready    = rdy;
    @(posedge clk);
    model_step();
    #1;
    check("pc", pc, m_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(!m_booting && !m_halted));
    check("halted", 32'(halted), 32'(m_halted));
    check("trap_pulse", 32'(trap_pulse), 32'(m_trap));
  endtask

  initial begin
    // 1: reset then free-running fetch
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    check("reset_pc", pc, ResetVec);
    check("reset_valid", 32'(fetch_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("first_valid", 32'(fetch_valid), 32'd1);
    check("first_pc", pc, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    check("seq_pc", pc, 32'h10);

    // 2: stall holds pc
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("stall_pc", pc, 32'h10);
    check("stall_valid", 32'(fetch_valid), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    check("unstall_pc", pc, 32'h14);

    // 3: redirect beats handshake
    step(0, 1, 32'h200, 0, 0, 1);
    check("redir_pc", pc, 32'h200);
    step(0, 0, 0, 0, 0, 1);
    check("redir_next", pc, 32'h204);

    // 4: halt waits for handshake; redirect and resume in HALT
    step(0, 1, 32'h20, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("halt_wait", 32'(halted), 32'd0);
    step(0, 0, 0, 1, 0, 1);
    check("halt_pc", pc, 32'h24);
    check("halt_flag", 32'(halted), 32'd1);
    step(0, 1, 32'h80, 0, 0, 1);
    check("halt_redir", pc, 32'h80);
    check("halt_redir_flag", 32'(halted), 32'd1);
    step(0, 0, 0, 1, 1, 1);
    check("resume_blocked", 32'(halted), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    check("resume_valid", 32'(fetch_valid), 32'd1);
    check("resume_pc", pc, 32'h80);

    // 5: wrap, then reset mid-stall
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_pc", pc, 32'h0);
    step(0, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("midrst_pc", pc, ResetVec);
    check("midrst_valid", 32'(fetch_valid), 32'd0);
    step(0, 1, 32'h300, 0, 0, 0);
    check("boot_redir_ignored", pc, ResetVec);

    // 6: misaligned redirect
    step(0, 1, 32'h102, 0, 0, 0);
    check("misalign_pc", pc, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_trap", 32'(trap_pulse), 32'd1);
`else
    check("misalign_trap", 32'(trap_pulse), 32'd0);
`endif
    step(0, 0, 0, 0, 0, 0);
    check("trap_clear", 32'(trap_pulse), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
